// File: rtl/mux_pkg.sv
// mux_pkg
//   Shared definitions for the stream multiplexer / arbiter slice.
//   - ARB_RR / ARB_FIXED : arbitration policy encodings for the MODE parameter
//   - clog2_floor1()     : index width for N channels, never narrower than 1 bit
package mux_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // A single channel still needs a 1-bit index so port widths stay legal.
    function automatic int clog2_floor1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Purely combinational grant logic for stream_mux_arb.
//   Ports:
//     req       in  N_CH  request (input valid) per channel
//     ptr       in  CH_W  round-robin start position (ignored for fixed priority)
//     lock      in  1     packet lock active: only lock_ch may be granted
//     lock_ch   in  CH_W  channel holding the lock
//     grant     out N_CH  one-hot grant, or all zero when nothing is eligible
//     grant_idx out CH_W  binary index of the granted channel (0 when none)
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int MODE = ARB_RR,
    parameter int CH_W = 2
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    input  logic            lock,
    input  logic [CH_W-1:0] lock_ch,
    output logic [N_CH-1:0] grant,
    output logic [CH_W-1:0] grant_idx
);

    always_comb begin
        int c;
        c         = 0;
        grant     = '0;
        grant_idx = '0;
        if (lock) begin
            for (int i = 0; i < N_CH; i++) begin
                if (lock_ch == CH_W'(i) && req[i]) begin
                    grant[i]  = 1'b1;
                    grant_idx = CH_W'(i);
                end
            end
        end else if (MODE == ARB_FIXED) begin
            // Scan from the top down so the lowest requesting index is the last writer.
            for (int i = N_CH - 1; i >= 0; i--) begin
                if (req[i]) begin
                    grant     = '0;
                    grant[i]  = 1'b1;
                    grant_idx = CH_W'(i);
                end
            end
        end else begin
            // Same trick on the rotated order: offset 0 from ptr wins.
            for (int k = N_CH - 1; k >= 0; k--) begin
                c = int'(ptr) + k;
                if (c >= N_CH) c = c - N_CH;
                if (req[c]) begin
                    grant     = '0;
                    grant[c]  = 1'b1;
                    grant_idx = CH_W'(c);
                end
            end
        end
    end

endmodule

// File: rtl/stream_mux_arb.sv
// stream_mux_arb
//   N-channel valid/ready stream multiplexer with a built-in arbiter and one
//   registered output stage. Packet lock keeps multi-beat packets contiguous.
//   Ports:
//     clk, rst    clock, asynchronous active-high reset
//     in_valid    N_CH         per-channel valid
//     in_ready    N_CH         per-channel ready (combinational, at most one set)
//     in_data     N_CH*WIDTH   packed data, channel i at [i*WIDTH +: WIDTH]
//     in_last     N_CH         per-channel end-of-packet flag
//     out_valid   1            registered output valid
//     out_ready   1            consumer ready
//     out_data    WIDTH        registered data
//     out_ch      CH_W         registered source channel
//     out_last    1            registered last flag
module stream_mux_arb
    import mux_pkg::*;
#(
    parameter  int N_CH     = 4,
    parameter  int WIDTH    = 8,
    parameter  int MODE     = ARB_RR,
    parameter  int PKT_LOCK = 1,
    localparam int CH_W     = clog2_floor1(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [CH_W-1:0]       out_ch,
    output logic                  out_last
);

    logic [CH_W-1:0]  ptr;
    logic             lock;
    logic [CH_W-1:0]  lock_ch;

    logic [N_CH-1:0]  grant_p0;
    logic [CH_W-1:0]  grant_idx_p0;
    logic             load_en_p0;
    logic             vld_p0;
    logic [WIDTH-1:0] sel_data_p0;
    logic             sel_last_p0;
    logic [CH_W-1:0]  ptr_next_p0;

    // ---- stage p0: arbitration and input selection (combinational) ----
    rr_arbiter #(
        .N_CH (N_CH),
        .MODE (MODE),
        .CH_W (CH_W)
    ) u_arb (
        .req       (in_valid),
        .ptr       (ptr),
        .lock      (lock),
        .lock_ch   (lock_ch),
        .grant     (grant_p0),
        .grant_idx (grant_idx_p0)
    );

    // The output register can take a beat when empty or draining this cycle.
    assign load_en_p0 = !out_valid || out_ready;
    assign in_ready   = (rst || !load_en_p0) ? '0 : grant_p0;
    assign vld_p0     = |in_ready;

    always_comb begin
        sel_data_p0 = '0;
        sel_last_p0 = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant_p0[i]) begin
                sel_data_p0 = in_data[i*WIDTH +: WIDTH];
                sel_last_p0 = in_last[i];
            end
        end
    end

    assign ptr_next_p0 = (grant_idx_p0 == CH_W'(N_CH - 1)) ? '0 : grant_idx_p0 + 1'b1;

    // ---- stage p1: output register, pointer and lock state ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
            ptr       <= '0;
            lock      <= 1'b0;
            lock_ch   <= '0;
        end else if (vld_p0) begin
            out_valid <= 1'b1;
            out_data  <= sel_data_p0;
            out_ch    <= grant_idx_p0;
            out_last  <= sel_last_p0;
            if (PKT_LOCK != 0 && !sel_last_p0) begin
                lock    <= 1'b1;
                lock_ch <= grant_idx_p0;
            end else begin
                // Pointer only advances once the packet (or single beat) is done.
                lock <= 1'b0;
                if (MODE == ARB_RR) ptr <= ptr_next_p0;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/stream_mux_arb.md
Name: stream_mux_arb

Overview:
- Parametrised N-channel streaming multiplexer. Successor to the combinational 2:1 and 4:1 muxes.
- Selection is driven by a built-in arbiter, not an external select.
- Each input is a valid/ready stream. The winner is forwarded through one registered output stage carrying data, source index and last flag.
- Packet lock keeps a multi-beat transfer contiguous. Sits between several producers and one shared consumer, e.g. a bus or UART TX.

Parameters:
- N_CH, 4, number of input channels (>=1; need not be a power of two).
- WIDTH, 8, data width per channel.
- MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority (lowest index wins).
- PKT_LOCK, 1, 1 = hold grant until a beat with last=1 is accepted; 0 = re-arbitrate every beat.
- CH_W, max(1,$clog2(N_CH)), derived width of channel index (localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  N_CH  per-channel valid
- in_ready  output  N_CH  per-channel ready (combinational)
- in_data  input  N_CH*WIDTH  packed data; channel i at [i*WIDTH +: WIDTH]
- in_last  input  N_CH  per-channel end-of-packet flag
- out_valid  output  1  registered output valid
- out_ready  input  1  consumer ready
- out_data  output  WIDTH  registered data
- out_ch  output  CH_W  registered source channel index
- out_last  output  1  registered last flag

Behaviour:
- Reset (async, immediate): out_valid=0, out_data=0, out_ch=0, out_last=0, rr pointer=0, lock=0, locked channel=0. in_ready=0 while rst high.
- Transfer rules:
  - Input beat transfers when in_valid[i] & in_ready[i].
  - Output beat transfers when out_valid & out_ready.
- load_en = !out_valid | out_ready. The output register accepts a new beat whenever it is empty or being drained in the same cycle.
- Grant (combinational, one-hot or zero):
  - If lock=1: only the locked channel is eligible.
  - Else MODE 0: first valid channel searched from rr pointer upward, wrapping at N_CH-1 to 0.
  - Else MODE 1: lowest-index valid channel.
- in_ready[i] = grant[i] & load_en. At most one bit is set. in_ready never depends on in_ready, and never on in_valid of the same channel only.
- On input transfer from channel g:
  - out_data <= in_data[g], out_ch <= g, out_last <= in_last[g], out_valid <= 1.
  - If PKT_LOCK=1 and in_last[g]=0: lock <= 1, locked channel <= g.
  - If in_last[g]=1 or PKT_LOCK=0: lock <= 0.
  - MODE 0: rr pointer <= (g==N_CH-1) ? 0 : g+1, updated only when the lock is released or not taken (i.e. on a beat with last=1 or PKT_LOCK=0).
- Output transfer with no input transfer the same cycle: out_valid <= 0; out_data/out_ch/out_last hold their last values.
- Backpressure: while out_valid=1 and out_ready=0, all out_* hold stable, in_ready=0, and the pointer and lock do not change.
- Latency and throughput:
  - Latency is 1 cycle from input transfer to out_valid.
  - Sustained throughput is 1 beat/cycle with out_ready held high (simultaneous drain and load).
- Locked channel deasserts in_valid mid-packet: no grant to any channel; lock held; output drains normally.
- Reset mid-packet: lock cleared, packet fragment discarded. No recovery logic.
- No valid inputs: grant=0, output drains, state unchanged.
- N_CH=1: arbiter degenerates to pass-through plus register; out_ch is a constant 0.
- in_last is ignored for locking when PKT_LOCK=0 but is still forwarded.

Decomposition:
- Shared package (mux_pkg): MODE encodings (ARB_RR=0, ARB_FIXED=1) and a clog2-with-floor-1 function for CH_W.
- One sub-module: rr_arbiter. Inputs: req[N_CH], ptr, lock, lock_ch. Output: grant[N_CH] and grant index. It is purely combinational and MODE-selectable.
- The top level holds the output register, pointer and lock state.

Test Plan:
- Reset, then in_valid=4'b1111, out_ready=1, PKT_LOCK=0, MODE 0, in_last=1111 -> out_ch sequence 0,1,2,3,0 on consecutive cycles; out_data matches each channel's value.
- MODE 1, in_valid=4'b1010 held -> every beat from channel 1; channel 3 is never granted (starvation expected).
- PKT_LOCK=1:
  - Channel 2 sends 3 beats, last on the 3rd; channel 0 is valid throughout.
  - Expected: out_ch=2,2,2 contiguous, then 0; pointer moves to 3 after the last beat.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1, data=8'hA5 -> out_* stable, in_ready=0. Then out_ready=1 -> the next beat loads in the same cycle A5 drains.
- Async reset asserted mid-packet (lock=1, out_valid=1) between clock edges -> out_valid=0 immediately; after release, arbitration restarts from channel 0 with lock=0.
- N_CH=3, WIDTH=16, all valid, MODE 0 -> out_ch wraps 0,1,2,0; no index 3 is ever produced.
